chip8_sprite_draw: RTL and testbench
====================================

CHIP8_SPRITE_DRAW -- requirements
Module: chip8_sprite_draw

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; reset_n  in  1  synchronous active-low reset.
REQ-002 SHALL have ports: start  in  1  one-cycle draw request (DXYN); vx  in  8  X coordinate; vy  in  8  Y coordinate; n  in  4  sprite rows; i_reg  in  12  sprite base address.
REQ-003 SHALL have ports: mem_addr  out  12  sprite memory address; mem_data  in  8  sprite byte, valid 1 cycle after mem_addr.
REQ-004 SHALL have framebuffer ports: fbvx_read, fbvy_read  out  8  read byte position; fb_readdata  in  8  registered read data, 1-cycle latency.
REQ-005 SHALL have framebuffer ports: fbvx_write, fbvy_write  out  8  write byte position; fbdata  out  8; fb_write  out  1.
REQ-006 SHALL have status ports: busy  out  1; done  out  1  one-cycle completion pulse; collision  out  1  VF result.

Function
REQ-007 Framebuffer byte access at (c,r) SHALL cover pixels c..c+7 of row r, with pixel c+k in bit k; sprite bit 7-k SHALL map to pixel c+k.
REQ-008 start SHALL be accepted only in IDLE; accepting it SHALL latch xw=vx mod 64, yw=vy mod 32, n, i_reg, clear collision, and set busy on the next cycle.
REQ-009 start while busy SHALL be ignored.
REQ-010 FSM states: IDLE, FETCH, RDFB, MERGE, RDFB2, MERGE2, DONE.
REQ-011 FETCH SHALL drive mem_addr = (i_reg + row) mod 4096, then go to RDFB.
REQ-012 RDFB SHALL latch mem_data as the sprite byte and drive fbvx_read=xw, fbvy_read=(yw+row) mod 32.
REQ-013 MERGE SHALL assert fb_write for exactly one cycle, at the write position equal to the RDFB read position.
REQ-014 In MERGE, fbdata bits k < L SHALL equal fb_readdata[k] XOR sprite bit (7-k), where L=min(8, 64-xw); bits k >= L SHALL equal fb_readdata[k] unchanged.
REQ-015 If L<8, MERGE SHALL go to RDFB2, which reads column 0 of the same row.
REQ-016 MERGE2 SHALL write column 0 with bits k < 8-L XORed with sprite bit (7-L-k), and all other bits unchanged.
REQ-017 After the last segment of a row, the FSM SHALL increment row and go to FETCH while row < n, otherwise to DONE.
REQ-018 Row timing: 3 cycles per non-wrapped row, 5 cycles per wrapped row; DONE SHALL last 1 cycle, pulse done, clear busy, and return to IDLE.
REQ-019 n=0 SHALL go from IDLE directly to DONE, with no memory or framebuffer access and collision=0.
REQ-020 Collision SHALL be set if any XORed bit had fb_readdata=1 and sprite bit=1; it SHALL be sticky for the draw and held until the next accepted start.
REQ-021 Y SHALL wrap mod 32 per row; the XOR writes SHALL never touch pixels outside the sprite footprint.
REQ-022 fb_write SHALL be 0 in every state except MERGE and MERGE2.

Reset
REQ-023 When reset_n=0 at a clk edge: state=IDLE; busy, done, collision and fb_write=0; mem_addr=0; all framebuffer addresses=0; fbdata=0.
REQ-024 Reset mid-draw SHALL abort without completing the draw; fb_write SHALL be 0 from the reset edge, and no done pulse SHALL be issued.

Structure
REQ-025 Shared package chip8_pkg SHALL hold FB_WIDTH=64, FB_HEIGHT=32, MEM_AW=12, and the draw FSM state enum type.
REQ-026 Combinational sub-module chip8_sprite_rowmerge SHALL compute (old byte, sprite byte, bit offset, segment select) -> (new byte, hit).

Verification
REQ-027 vx=8, vy=4, n=1, mem[0x300]=0xF0, fb byte=0x00 -> one write of 0x0F at (8,4); collision=0; done pulsed 4 cycles after start.
REQ-028 Same draw repeated on an fb byte of 0x0F -> write of 0x00; collision=1.
REQ-029 vx=60, vy=0, n=1, sprite=0xFF -> write at (60,0) bits 0-3 toggled and bits 4-7 preserved, then write at (0,0) bits 0-3 toggled; 5-cycle row.
REQ-030 vy=30, n=4 -> rows written at y=30, 31, 0, 1 in order; memory addresses i_reg..i_reg+3.
REQ-031 n=0 -> done 1 cycle after start; no fb_write; collision=0. A start pulse while busy -> ignored.
REQ-032 reset_n low during the MERGE of row 2 of 5 -> fb_write=0 on the next cycle, state=IDLE, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/chip8_pkg.sv
// ---------------------------------------------------------------------------
// chip8_pkg
//
// Shared constants and types for the CHIP-8 sprite drawing engine.
//   FB_WIDTH / FB_HEIGHT : display size in pixels (64 x 32)
//   MEM_AW               : sprite memory address width (4 KiB address space)
//   draw_state_t         : state encoding of the DXYN draw sequencer
//   first_seg_len()      : number of sprite pixels that fit before the
//                          right-hand screen edge for a given X start
// ---------------------------------------------------------------------------
package chip8_pkg;

    localparam int FB_WIDTH  = 64;
    localparam int FB_HEIGHT = 32;
    localparam int MEM_AW    = 12;
    localparam int XW        = $clog2(FB_WIDTH);   // bits of a wrapped X coordinate
    localparam int YW        = $clog2(FB_HEIGHT);  // bits of a wrapped Y coordinate
    localparam int BYTE_BITS = 8;                  // pixels per sprite row / fb byte

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_RDFB   = 3'd2,
        ST_MERGE  = 3'd3,
        ST_RDFB2  = 3'd4,
        ST_MERGE2 = 3'd5,
        ST_DONE   = 3'd6
    } draw_state_t;

    // L = min(8, 64 - xw): pixels of the row that land at or right of xw.
    // When L < 8 the remaining 8-L pixels wrap around to column 0.
    function automatic logic [3:0] first_seg_len(input logic [XW-1:0] xw);
        logic [XW:0] rem;
        rem = (XW+1)'(FB_WIDTH) - {1'b0, xw};
        if (rem >= (XW+1)'(BYTE_BITS)) begin
            return 4'd8;
        end
        return rem[3:0];
    endfunction

endpackage

// File: rtl/chip8_sprite_rowmerge.sv
// ---------------------------------------------------------------------------
// chip8_sprite_rowmerge
//
// Purely combinational XOR merge of one sprite row into one framebuffer byte.
// A framebuffer byte at column c holds pixel c+k in bit k, whereas the sprite
// byte holds its leftmost pixel in bit 7, so the sprite is bit-reversed first.
//
// Ports:
//   old_byte    in  8  framebuffer byte as read back
//   sprite_byte in  8  sprite row (bit 7 = leftmost pixel)
//   seg_len     in  4  L = pixels of the row left of the right screen edge (1..8)
//   seg_sel     in  1  0: segment at xw (bits k < L toggled)
//                      1: wrapped segment at column 0 (bits k < 8-L toggled)
//   new_byte    out 8  byte to write back
//   hit         out 1  a set sprite pixel landed on a set framebuffer pixel
// ---------------------------------------------------------------------------
module chip8_sprite_rowmerge
    import chip8_pkg::*;
(
    input  logic [BYTE_BITS-1:0] old_byte,
    input  logic [BYTE_BITS-1:0] sprite_byte,
    input  logic [3:0]           seg_len,
    input  logic                 seg_sel,
    output logic [BYTE_BITS-1:0] new_byte,
    output logic                 hit
);

    logic [BYTE_BITS-1:0] sprite_rev;
    logic [BYTE_BITS-1:0] keep_mask;
    logic [BYTE_BITS-1:0] seg0_bits;
    logic [BYTE_BITS-1:0] seg1_bits;
    logic [BYTE_BITS-1:0] toggle_bits;

    // sprite_rev[k] is the sprite pixel that belongs at framebuffer bit k
    genvar gi;
    generate
        for (gi = 0; gi < BYTE_BITS; gi++) begin : g_rev
            assign sprite_rev[gi] = sprite_byte[BYTE_BITS-1-gi];
        end
    endgenerate

    always_comb begin
        // Bits at or above L lie past the screen edge and must stay untouched.
        // A shift by 8 empties the mask, so L=8 toggles the full byte.
        keep_mask   = 8'hFF << seg_len;
        seg0_bits   = sprite_rev & ~keep_mask;
        // Wrapped part: fb bit k of column 0 takes sprite bit 7-L-k, i.e.
        // sprite_rev[L+k]; the shift also zero-fills bits k >= 8-L.
        seg1_bits   = sprite_rev >> seg_len;
        toggle_bits = seg_sel ? seg1_bits : seg0_bits;
        new_byte    = old_byte ^ toggle_bits;
        hit         = |(old_byte & toggle_bits);
    end

endmodule

// File: rtl/chip8_sprite_draw.sv
// ---------------------------------------------------------------------------
// chip8_sprite_draw
//
// CHIP-8 DXYN sprite drawing engine. Reads n sprite rows from memory starting
// at i_reg and XORs them into a byte-windowed framebuffer at (vx, vy) with
// wrap-around on both axes, reporting pixel collisions (VF).
//
// Row sequence: FETCH (memory address out) -> RDFB (sprite byte in, fb read
// address out) -> MERGE (fb data in, XORed byte written back). A row that
// crosses the right edge adds RDFB2/MERGE2 for the part wrapped to column 0.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   start                    one-cycle draw request, honoured only when idle
//   vx, vy, n, i_reg         draw coordinates, row count, sprite address
//   mem_addr / mem_data      sprite memory, data valid one cycle after address
//   fbvx_read, fbvy_read     framebuffer read position (pixel column, row)
//   fb_readdata              framebuffer read data, one-cycle latency
//   fbvx_write, fbvy_write   framebuffer write position
//   fbdata, fb_write         framebuffer write data and strobe
//   busy                     draw in progress
//   done                     one-cycle completion pulse
//   collision                VF result of the most recent draw
// ---------------------------------------------------------------------------
module chip8_sprite_draw
    import chip8_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        vx,
    input  logic [7:0]        vy,
    input  logic [3:0]        n,
    input  logic [MEM_AW-1:0] i_reg,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        fbvx_read,
    output logic [7:0]        fbvy_read,
    input  logic [7:0]        fb_readdata,
    output logic [7:0]        fbvx_write,
    output logic [7:0]        fbvy_write,
    output logic [7:0]        fbdata,
    output logic              fb_write,
    output logic              busy,
    output logic              done,
    output logic              collision
);

    draw_state_t       state_reg;
    logic [XW-1:0]     xw_reg;
    logic [YW-1:0]     yw_reg;
    logic [3:0]        n_reg;
    logic [3:0]        row_reg;
    logic [MEM_AW-1:0] ibase_reg;
    logic [7:0]        sprite_reg;
    logic [MEM_AW-1:0] mem_addr_reg;
    logic [XW-1:0]     fb_x_reg;
    logic [YW-1:0]     fb_y_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              collision_reg;

    logic [3:0]        seg_len;
    logic              row_wraps;
    logic [YW-1:0]     row_y;
    logic [4:0]        row_plus1;
    logic              more_rows;
    logic              in_merge;
    logic              seg_sel;
    logic [7:0]        merged_byte;
    logic              merge_hit;

    // Coordinates are taken mod 64 / mod 32, so the upper input bits are
    // intentionally ignored.
    logic              unused_bits;
    assign unused_bits = &{1'b0, vx[7:XW], vy[7:YW]};

    always_comb begin
        seg_len   = first_seg_len(xw_reg);
        row_wraps = (seg_len != 4'd8);
        // YW-bit addition wraps the row index mod FB_HEIGHT for free
        row_y     = yw_reg + YW'(row_reg);
        row_plus1 = {1'b0, row_reg} + 5'd1;
        more_rows = (row_plus1 < {1'b0, n_reg});
        in_merge  = (state_reg == ST_MERGE) || (state_reg == ST_MERGE2);
        seg_sel   = (state_reg == ST_MERGE2);
    end

    chip8_sprite_rowmerge u_rowmerge (
        .old_byte    (fb_readdata),
        .sprite_byte (sprite_reg),
        .seg_len     (seg_len),
        .seg_sel     (seg_sel),
        .new_byte    (merged_byte),
        .hit         (merge_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            xw_reg        <= '0;
            yw_reg        <= '0;
            n_reg         <= '0;
            row_reg       <= '0;
            ibase_reg     <= '0;
            sprite_reg    <= '0;
            mem_addr_reg  <= '0;
            fb_x_reg      <= '0;
            fb_y_reg      <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        xw_reg        <= vx[XW-1:0];
                        yw_reg        <= vy[YW-1:0];
                        n_reg         <= n;
                        ibase_reg     <= i_reg;
                        row_reg       <= '0;
                        collision_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (n == 4'd0) begin
                            // empty sprite: no memory or framebuffer traffic
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            mem_addr_reg <= i_reg;
                            state_reg    <= ST_FETCH;
                        end
                    end
                end

                ST_FETCH: begin
                    // read and write positions coincide for the whole segment
                    fb_x_reg  <= xw_reg;
                    fb_y_reg  <= row_y;
                    state_reg <= ST_RDFB;
                end

                ST_RDFB: begin
                    sprite_reg <= mem_data;
                    state_reg  <= ST_MERGE;
                end

                ST_MERGE, ST_MERGE2: begin
                    if (merge_hit) begin
                        collision_reg <= 1'b1;
                    end
                    if ((state_reg == ST_MERGE) && row_wraps) begin
                        fb_x_reg  <= '0;
                        state_reg <= ST_RDFB2;
                    end else if (more_rows) begin
                        row_reg      <= row_plus1[3:0];
                        mem_addr_reg <= ibase_reg + MEM_AW'(row_plus1);
                        state_reg    <= ST_FETCH;
                    end else begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end

                ST_RDFB2: begin
                    state_reg <= ST_MERGE2;
                end

                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // The write strobe is decoded straight from the state register so that it
    // drops on the same edge that a reset takes effect.
    assign fb_write   = in_merge;
    assign fbdata     = in_merge ? merged_byte : 8'h00;

    assign mem_addr   = mem_addr_reg;
    assign fbvx_read  = 8'(fb_x_reg);
    assign fbvy_read  = 8'(fb_y_reg);
    assign fbvx_write = 8'(fb_x_reg);
    assign fbvy_write = 8'(fb_y_reg);
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign collision  = collision_reg;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// ---------------------------------------------------------------------------
// tb_chip8_sprite_draw
//
// Bench for chip8_sprite_draw. Sprite memory and a 64x32 pixel framebuffer are
// emulated here; the framebuffer carries 8 extra columns past the right edge
// so that any write outside the sprite footprint shows up in the image
// comparison. The reference model draws pixel by pixel with mod-64/mod-32
// wrap, the way a CHIP-8 interpreter does.
// ---------------------------------------------------------------------------
module tb_chip8_sprite_draw;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  vx, vy;
    logic [3:0]  n;
    logic [11:0] i_reg;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  fbvx_read, fbvy_read, fb_readdata;
    logic [7:0]  fbvx_write, fbvy_write, fbdata;
    logic        fb_write, busy, done, collision;

    always #5 clk = ~clk;

    chip8_sprite_draw dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .vx          (vx),
        .vy          (vy),
        .n           (n),
        .i_reg       (i_reg),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .fbvx_read   (fbvx_read),
        .fbvy_read   (fbvy_read),
        .fb_readdata (fb_readdata),
        .fbvx_write  (fbvx_write),
        .fbvy_write  (fbvy_write),
        .fbdata      (fbdata),
        .fb_write    (fb_write),
        .busy        (busy),
        .done        (done),
        .collision   (collision)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] mem [0:4095];
    logic       fbpix [0:31][0:71];   // emulated framebuffer (+8 guard columns)
    logic       mpix  [0:31][0:71];   // reference image

    typedef struct {
        int          x;
        int          y;
        logic [7:0]  d;
        logic [11:0] a;
    } wr_t;
    wr_t        wq[$];
    logic [11:0] ma_h1, ma_h2;

    function automatic logic [7:0] fb_byte(input int x, input int y);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (x >= 0 && x + k < 72 && y >= 0 && y < 32) b[k] = fbpix[y][x+k];
        end
        return b;
    endfunction

    function automatic logic [7:0] model_byte(input int x, input int y);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) b[k] = mpix[y][x+k];
        return b;
    endfunction

    function automatic int img_diff();
        int d;
        d = 0;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 72; x++)
                if (fbpix[y][x] !== mpix[y][x]) d++;
        return d;
    endfunction

    // Memory and framebuffer emulation: registered reads, one-cycle latency.
    always @(posedge clk) begin
        mem_data    <= mem[mem_addr];
        fb_readdata <= fb_byte(int'(fbvx_read), int'(fbvy_read));
        if (fb_write === 1'b1 && fbvx_write < 8'd64 && fbvy_write < 8'd32) begin
            for (int k = 0; k < 8; k++) fbpix[fbvy_write][int'(fbvx_write) + k] = fbdata[k];
        end
    end

    // Write monitor; each entry also carries the memory address from two
    // cycles before the write, i.e. the FETCH address of that row.
    always @(negedge clk) begin
        if (fb_write === 1'b1) wq.push_back('{int'(fbvx_write), int'(fbvy_write), fbdata, ma_h2});
        ma_h2 = ma_h1;
        ma_h1 = mem_addr;
    end

    // Reference: CHIP-8 pixel-by-pixel XOR draw with wrap on both axes.
    task automatic model_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] nn,
                              input logic [11:0] ii, output logic coll, output int nwr, output int lat);
        int xw, yw, px, py;
        logic [7:0] b;
        xw   = int'(x) % 64;
        yw   = int'(y) % 32;
        coll = 1'b0;
        for (int r = 0; r < int'(nn); r++) begin
            b = mem[(int'(ii) + r) % 4096];
            for (int j = 0; j < 8; j++) begin
                if (b[7-j]) begin
                    px = (xw + j) % 64;
                    py = (yw + r) % 32;
                    if (mpix[py][px]) coll = 1'b1;
                    mpix[py][px] = ~mpix[py][px];
                end
            end
        end
        nwr = int'(nn) * ((xw > 56) ? 2 : 1);
        lat = (nn == 4'd0) ? 1 : int'(nn) * ((xw > 56) ? 5 : 3) + 1;
    endtask

    // Issue one draw and wait (bounded) for done. At cycle glitch_at a second
    // start with different parameters is raised while the draw is running.
    task automatic run_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] nn,
                            input logic [11:0] ii, input int glitch_at,
                            output int lat, output logic busy1);
        wq.delete();
        @(negedge clk);
        vx = x; vy = y; n = nn; i_reg = ii; start = 1'b1;
        lat   = -1;
        busy1 = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == glitch_at) begin
                start = 1'b1; vx = 8'd40; vy = 8'd9; n = 4'd2; i_reg = 12'h500;
            end else begin
                start = 1'b0;
            end
            if (c == 1) busy1 = busy;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        $display("draw vx=%0d vy=%0d n=%0d i=%03h latency=%0d writes=%0d collision=%0b",
                 x, y, nn, ii, lat, wq.size(), collision);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; vx = 8'd0; vy = 8'd0; n = 4'd0; i_reg = 12'h000;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({busy, done, collision, fb_write} !== 4'b0000)
            $display("FAIL reset_status: got busy/done/coll/wr=%b required 0000", {busy, done, collision, fb_write});
        else pass_cnt++;
        chk_cnt++;
        if (mem_addr !== 12'h000) $display("FAIL reset_mem_addr: got %03h required 000", mem_addr);
        else pass_cnt++;
        chk_cnt++;
        if ({fbvx_read, fbvy_read, fbvx_write, fbvy_write} !== 32'h0)
            $display("FAIL reset_fb_pos: got %08h required 00000000", {fbvx_read, fbvy_read, fbvx_write, fbvy_write});
        else pass_cnt++;
        chk_cnt++;
        if (fbdata !== 8'h00) $display("FAIL reset_fbdata: got %02h required 00", fbdata);
        else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic ec, b1;
        int   enw, elat, lat;
        logic [7:0] exp_d [0:1];
        exp_d[0] = 8'h0F;
        exp_d[1] = 8'h00;
        mem[12'h300] = 8'hF0;
        for (int pass = 0; pass < 2; pass++) begin
            model_draw(8'd8, 8'd4, 4'd1, 12'h300, ec, enw, elat);
            run_draw(8'd8, 8'd4, 4'd1, 12'h300, 0, lat, b1);
            chk_cnt++;
            if (lat !== 4) $display("FAIL basic_latency: got %0d required 4", lat);
            else pass_cnt++;
            chk_cnt++;
            if (b1 !== 1'b1) $display("FAIL basic_busy: got %b required 1", b1);
            else pass_cnt++;
            chk_cnt++;
            if (wq.size() !== 1) $display("FAIL basic_write_count: got %0d required 1", wq.size());
            else pass_cnt++;
            if (wq.size() > 0) begin
                chk_cnt++;
                if (wq[0].x !== 8 || wq[0].y !== 4 || wq[0].d !== exp_d[pass])
                    $display("FAIL basic_write: got (%0d,%0d)=%02h required (8,4)=%02h",
                             wq[0].x, wq[0].y, wq[0].d, exp_d[pass]);
                else pass_cnt++;
            end
            chk_cnt++;
            if (collision !== ec) $display("FAIL basic_collision: got %b required %b", collision, ec);
            else pass_cnt++;
        end
    endtask

    task automatic test_x_wrap();
        logic ec, b1;
        int   enw, elat, lat;
        logic [7:0] old_hi, old_lo;
        for (int x = 0; x < 72; x++) begin
            fbpix[0][x] = 1'($urandom_range(0, 1));
            mpix[0][x]  = fbpix[0][x];
        end
        mem[12'h310] = 8'hFF;
        old_hi = model_byte(60, 0);
        old_lo = model_byte(0, 0);
        model_draw(8'd60, 8'd0, 4'd1, 12'h310, ec, enw, elat);
        run_draw(8'd60, 8'd0, 4'd1, 12'h310, 0, lat, b1);
        chk_cnt++;
        if (lat !== 6) $display("FAIL xwrap_latency: got %0d required 6", lat);
        else pass_cnt++;
        chk_cnt++;
        if (wq.size() !== 2) $display("FAIL xwrap_write_count: got %0d required 2", wq.size());
        else pass_cnt++;
        if (wq.size() >= 2) begin
            chk_cnt++;
            if (wq[0].x !== 60 || wq[0].y !== 0 || wq[0].d !== (old_hi ^ 8'h0F))
                $display("FAIL xwrap_first: got (%0d,%0d)=%02h required (60,0)=%02h",
                         wq[0].x, wq[0].y, wq[0].d, old_hi ^ 8'h0F);
            else pass_cnt++;
            chk_cnt++;
            if (wq[1].x !== 0 || wq[1].y !== 0 || wq[1].d !== (old_lo ^ 8'h0F))
                $display("FAIL xwrap_second: got (%0d,%0d)=%02h required (0,0)=%02h",
                         wq[1].x, wq[1].y, wq[1].d, old_lo ^ 8'h0F);
            else pass_cnt++;
        end
        chk_cnt++;
        if (collision !== ec) $display("FAIL xwrap_collision: got %b required %b", collision, ec);
        else pass_cnt++;
        chk_cnt++;
        if (img_diff() !== 0) $display("FAIL xwrap_image: got %0d differing pixels required 0", img_diff());
        else pass_cnt++;
    endtask

    task automatic test_y_wrap();
        logic ec, b1;
        int   enw, elat, lat;
        logic [11:0] base;
        base = 12'hFFE;   // also wraps the memory address past 0xFFF
        for (int r = 0; r < 4; r++) mem[(int'(base) + r) % 4096] = 8'($urandom);
        model_draw(8'd10, 8'd30, 4'd4, base, ec, enw, elat);
        run_draw(8'd10, 8'd30, 4'd4, base, 0, lat, b1);
        chk_cnt++;
        if (lat !== elat) $display("FAIL ywrap_latency: got %0d required %0d", lat, elat);
        else pass_cnt++;
        chk_cnt++;
        if (wq.size() !== 4) $display("FAIL ywrap_write_count: got %0d required 4", wq.size());
        else pass_cnt++;
        for (int r = 0; r < 4 && r < wq.size(); r++) begin
            chk_cnt++;
            if (wq[r].y !== (30 + r) % 32 || wq[r].a !== 12'(int'(base) + r))
                $display("FAIL ywrap_row%0d: got y=%0d addr=%03h required y=%0d addr=%03h",
                         r, wq[r].y, wq[r].a, (30 + r) % 32, 12'(int'(base) + r));
            else pass_cnt++;
        end
        chk_cnt++;
        if (collision !== ec) $display("FAIL ywrap_collision: got %b required %b", collision, ec);
        else pass_cnt++;
        chk_cnt++;
        if (img_diff() !== 0) $display("FAIL ywrap_image: got %0d differing pixels required 0", img_diff());
        else pass_cnt++;
    endtask

    task automatic test_zero_and_busy_start();
        logic ec, b1;
        int   enw, elat, lat;
        // leave collision set first so n=0 must actively clear it
        mem[12'h330] = 8'h80;
        model_draw(8'd1, 8'd1, 4'd1, 12'h330, ec, enw, elat);
        run_draw(8'd1, 8'd1, 4'd1, 12'h330, 0, lat, b1);
        model_draw(8'd1, 8'd1, 4'd1, 12'h330, ec, enw, elat);
        run_draw(8'd1, 8'd1, 4'd1, 12'h330, 0, lat, b1);
        chk_cnt++;
        if (collision !== 1'b1) $display("FAIL zero_precollision: got %b required 1", collision);
        else pass_cnt++;

        run_draw(8'd20, 8'd20, 4'd0, 12'h100, 0, lat, b1);
        chk_cnt++;
        if (lat !== 1) $display("FAIL zero_latency: got %0d required 1", lat);
        else pass_cnt++;
        chk_cnt++;
        if (wq.size() !== 0) $display("FAIL zero_writes: got %0d required 0", wq.size());
        else pass_cnt++;
        chk_cnt++;
        if (collision !== 1'b0) $display("FAIL zero_collision: got %b required 0", collision);
        else pass_cnt++;

        for (int r = 0; r < 3; r++) mem[12'h120 + r] = 8'($urandom);
        model_draw(8'd5, 8'd7, 4'd3, 12'h120, ec, enw, elat);
        run_draw(8'd5, 8'd7, 4'd3, 12'h120, 2, lat, b1);
        chk_cnt++;
        if (lat !== elat) $display("FAIL busystart_latency: got %0d required %0d", lat, elat);
        else pass_cnt++;
        chk_cnt++;
        if (wq.size() !== 3) $display("FAIL busystart_writes: got %0d required 3", wq.size());
        else pass_cnt++;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL busystart_idle: got busy=%b required 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (img_diff() !== 0) $display("FAIL busystart_image: got %0d differing pixels required 0", img_diff());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic ec, b1, saw_done;
        int   enw, elat, lat, wc;
        for (int r = 0; r < 5; r++) mem[12'h400 + r] = 8'($urandom);
        for (int r = 0; r < 3; r++) mem[12'h410 + r] = 8'($urandom);
        wq.delete();
        @(negedge clk);
        vx = 8'd20; vy = 8'd3; n = 4'd5; i_reg = 12'h400; start = 1'b1;
        wc = 0;
        for (int c = 0; c < 100 && wc < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (fb_write === 1'b1) wc++;
        end
        chk_cnt++;
        if (wc !== 2) $display("FAIL midreset_reach_row2: got %0d writes required 2", wc);
        else pass_cnt++;
        // the row-2 write in progress still lands; nothing after it may
        reset_n = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (fb_write !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset_abort: got fb_write=%b busy=%b required 0 0", fb_write, busy);
        else pass_cnt++;
        reset_n  = 1'b1;
        saw_done = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (done === 1'b1 || fb_write === 1'b1) saw_done = 1'b1;
        end
        chk_cnt++;
        if (saw_done !== 1'b0) $display("FAIL midreset_quiet: got activity=%b required 0", saw_done);
        else pass_cnt++;
        model_draw(8'd20, 8'd3, 4'd2, 12'h400, ec, enw, elat);
        chk_cnt++;
        if (img_diff() !== 0) $display("FAIL midreset_image: got %0d differing pixels required 0", img_diff());
        else pass_cnt++;
        $display("draw vx=20 vy=3 n=5 i=400 aborted by reset after %0d writes", wc);

        model_draw(8'd33, 8'd17, 4'd3, 12'h410, ec, enw, elat);
        run_draw(8'd33, 8'd17, 4'd3, 12'h410, 0, lat, b1);
        chk_cnt++;
        if (lat !== elat) $display("FAIL postreset_latency: got %0d required %0d", lat, elat);
        else pass_cnt++;
        chk_cnt++;
        if (collision !== ec) $display("FAIL postreset_collision: got %b required %b", collision, ec);
        else pass_cnt++;
        chk_cnt++;
        if (img_diff() !== 0) $display("FAIL postreset_image: got %0d differing pixels required 0", img_diff());
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic ec, b1;
        int   enw, elat, lat;
        logic [7:0]  x, y;
        logic [3:0]  nn;
        logic [11:0] ii;
        for (int it = 0; it < 16; it++) begin
            x  = (it % 2 == 1) ? 8'($urandom_range(57, 63) + 64 * $urandom_range(0, 3))
                               : 8'($urandom_range(0, 255));
            y  = 8'($urandom_range(0, 255));
            nn = 4'($urandom_range(0, 15));
            ii = 12'($urandom_range(0, 4095));
            model_draw(x, y, nn, ii, ec, enw, elat);
            run_draw(x, y, nn, ii, 0, lat, b1);
            chk_cnt++;
            if (lat !== elat) $display("FAIL rand%0d_latency: got %0d required %0d", it, lat, elat);
            else pass_cnt++;
            chk_cnt++;
            if (wq.size() !== enw) $display("FAIL rand%0d_writes: got %0d required %0d", it, wq.size(), enw);
            else pass_cnt++;
            chk_cnt++;
            if (collision !== ec) $display("FAIL rand%0d_collision: got %b required %b", it, collision, ec);
            else pass_cnt++;
            chk_cnt++;
            if (img_diff() !== 0) $display("FAIL rand%0d_image: got %0d differing pixels required 0", it, img_diff());
            else pass_cnt++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 72; x++) begin
                fbpix[y][x] = 1'b0;
                mpix[y][x]  = 1'b0;
            end
        ma_h1 = 12'h000;
        ma_h2 = 12'h000;

        test_reset();
        test_basic();
        test_x_wrap();
        test_y_wrap();
        test_zero_and_busy_start();
        test_reset_mid();
        test_random();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
